// File: rtl/store_buffer.sv
// store_buffer: word-store write buffer between the MEM stage and a
// single-ported data memory. Stores are queued and written to memory only in
// cycles where the port is not needed by a load or by an accepted store.
// Loads search the queue so they always see the newest stored value.
//
// Optional feature macro: STORE_BUFFER_FORWARD_EN
//   defined   - a load hitting the queue is served from the youngest match
//   undefined - a load hitting the queue stalls while the head drains
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   St_Valid/Addr/WData/PC  MEM-stage word store
//   Ld_Valid/Addr           MEM-stage word load
//   Ld_RData                load result to MEM/WB
//   Stall                   MEM stage must hold its instruction
//   DM_Addr/WData/MemWrite/PC  data-memory port drive
//   DM_RData                combinational data-memory read data
//   Empty                   queue holds no entries
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        St_Valid,
  input  logic [31:0] St_Addr,
  input  logic [31:0] St_WData,
  input  logic [31:0] St_PC,
  input  logic        Ld_Valid,
  input  logic [31:0] Ld_Addr,
  output logic [31:0] Ld_RData,
  output logic        Stall,
  output logic [31:0] DM_Addr,
  output logic [31:0] DM_WData,
  output logic        DM_MemWrite,
  output logic [31:0] DM_PC,
  input  logic [31:0] DM_RData,
  output logic        Empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [29:0]   addr_q [DEPTH];
  logic [29:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          full;
  logic          empty;
  logic          st_accept;
  logic          drain;
  logic          ld_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;
  logic          unused_bits;

  always_comb begin
    unused_bits = ^{St_Addr[1:0], Ld_Addr[1:0]};
  end

  // Scan oldest to youngest so the last hit left standing is the youngest.
  always_comb begin
    ld_hit   = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (addr_q[idx] == Ld_Addr[31:2])) begin
        ld_hit   = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (PW+1)'(DEPTH));
    st_accept = St_Valid && !full && !Ld_Valid;

    // Drain is suppressed while reset is high so discarded entries never
    // reach memory.
`ifdef STORE_BUFFER_FORWARD_EN
    drain = !reset && !empty && !Ld_Valid && !st_accept;
    Stall = St_Valid && (full || Ld_Valid);
    Ld_RData = ld_hit ? fwd_data : DM_RData;
`else
    drain = !reset && !empty &&
            ((!Ld_Valid && !st_accept) || (Ld_Valid && ld_hit));
    Stall = (St_Valid && (full || Ld_Valid)) || (Ld_Valid && ld_hit);
    Ld_RData = DM_RData;
`endif

    DM_Addr     = '0;
    DM_WData    = '0;
    DM_PC       = '0;
    DM_MemWrite = 1'b0;
    if (drain) begin
      DM_Addr     = {addr_q[head_q], 2'b00};
      DM_WData    = data_q[head_q];
      DM_PC       = pc_q[head_q];
      DM_MemWrite = 1'b1;
    end else if (Ld_Valid) begin
      DM_Addr = Ld_Addr;
    end

    Empty = empty;
  end

  // Accept and drain are mutually exclusive, so count moves by at most one.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (st_accept) begin
      addr_d[tail_q] = St_Addr[31:2];
      data_d[tail_q] = St_WData;
      pc_d[tail_q]   = St_PC;
      tail_d         = tail_q + 1'b1;
      count_d        = count_q + 1'b1;
    end else if (drain) begin
      head_d  = head_q + 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; it is only observed through valid slots.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4) with a small data-memory model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        St_Valid;
  logic [31:0] St_Addr, St_WData, St_PC;
  logic        Ld_Valid;
  logic [31:0] Ld_Addr;
  logic [31:0] Ld_RData;
  logic        Stall;
  logic [31:0] DM_Addr, DM_WData, DM_PC;
  logic        DM_MemWrite;
  logic [31:0] DM_RData;
  logic        Empty;

  int checks = 0;
  int errors = 0;
  int bad_wr = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .St_Valid(St_Valid), .St_Addr(St_Addr), .St_WData(St_WData), .St_PC(St_PC),
    .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_RData(Ld_RData),
    .Stall(Stall),
    .DM_Addr(DM_Addr), .DM_WData(DM_WData), .DM_MemWrite(DM_MemWrite),
    .DM_PC(DM_PC), .DM_RData(DM_RData), .Empty(Empty)
  );

  assign DM_RData = mem[DM_Addr[9:2]];

  always @(posedge clk) begin
    if (DM_MemWrite) begin
      mem[DM_Addr[9:2]] <= DM_WData;
      if (DM_Addr >= 32'h100 && DM_Addr <= 32'h108) bad_wr <= bad_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    St_Valid = 1'b0; St_Addr = '0; St_WData = '0; St_PC = '0;
    Ld_Valid = 1'b0; Ld_Addr = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    idle();
    St_Valid = 1'b1; St_Addr = a; St_WData = d; St_PC = pc;
  endtask

  task automatic load(input logic [31:0] a);
    idle();
    Ld_Valid = 1'b1; Ld_Addr = a;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 32'hDEADBEEF;
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_empty", Empty, 1);
    chk("rst_stall", Stall, 0);
    chk("rst_wr", DM_MemWrite, 0);

    // reset mid-operation
    tick(); store(32'h100, 32'h11, 32'h1000);
    tick(); store(32'h104, 32'h12, 32'h1004);
    tick(); store(32'h108, 32'h13, 32'h1008);
    tick(); idle(); reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_nowr", DM_MemWrite, 0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_empty", Empty, 1);
    chk("rst_mid_wr", DM_MemWrite, 0);
    tick(); tick(); tick();
    chk("rst_mid_discard", bad_wr, 0);

    // FIFO drain order with PC
    store(32'h10, 32'hA, 32'h200);
    @(negedge clk);
    chk("fifo_acc1_wr", DM_MemWrite, 0);
    tick(); store(32'h14, 32'hB, 32'h204);
    @(negedge clk);
    chk("fifo_acc2_wr", DM_MemWrite, 0);
    tick(); idle();
    @(negedge clk);
    chk("fifo_d1_wr", DM_MemWrite, 1);
    chk("fifo_d1_addr", DM_Addr, 32'h10);
    chk("fifo_d1_data", DM_WData, 32'hA);
    chk("fifo_d1_pc", DM_PC, 32'h200);
    tick();
    @(negedge clk);
    chk("fifo_d2_wr", DM_MemWrite, 1);
    chk("fifo_d2_addr", DM_Addr, 32'h14);
    chk("fifo_d2_data", DM_WData, 32'hB);
    chk("fifo_d2_pc", DM_PC, 32'h204);
    tick();
    @(negedge clk);
    chk("fifo_empty", Empty, 1);
    chk("fifo_idle_wr", DM_MemWrite, 0);
    chk("fifo_idle_addr", DM_Addr, 0);

    // full stall with DEPTH=4
    tick();
    for (int i = 0; i < 4; i++) begin
      store(32'h50 + 4*i, 32'h51 + i, 32'h300 + 4*i);
      @(negedge clk);
      chk("full_acc_stall", Stall, 0);
      tick();
    end
    store(32'h60, 32'h55, 32'h310);
    @(negedge clk);
    chk("full_stall", Stall, 1);
    chk("full_drain_wr", DM_MemWrite, 1);
    chk("full_drain_addr", DM_Addr, 32'h50);
    chk("full_drain_data", DM_WData, 32'h51);
    tick();
    @(negedge clk);
    chk("full_retry_stall", Stall, 0);
    chk("full_retry_wr", DM_MemWrite, 0);
    tick(); idle();
    tick(); tick(); tick(); tick();
    chk("full_empty", Empty, 1);
    for (int i = 0; i < 5; i++) chk("full_mem", mem[20 + i], 32'h51 + i);

    // youngest match
    store(32'h20, 32'h1, 32'h400);
    tick(); store(32'h20, 32'h2, 32'h404);
    tick(); load(32'h22);
    @(negedge clk);
`ifdef STORE_BUFFER_FORWARD_EN
    chk("fwd_data", Ld_RData, 32'h2);
    chk("fwd_stall", Stall, 0);
    chk("fwd_wr", DM_MemWrite, 0);
    tick(); idle();
    tick(); tick();
`else
    chk("nofwd_s1_stall", Stall, 1);
    chk("nofwd_s1_wr", DM_MemWrite, 1);
    chk("nofwd_s1_data", DM_WData, 32'h1);
    tick();
    @(negedge clk);
    chk("nofwd_s2_stall", Stall, 1);
    chk("nofwd_s2_wr", DM_MemWrite, 1);
    chk("nofwd_s2_data", DM_WData, 32'h2);
    tick();
    @(negedge clk);
    chk("nofwd_srv_stall", Stall, 0);
    chk("nofwd_srv_wr", DM_MemWrite, 0);
    chk("nofwd_srv_addr", DM_Addr, 32'h22);
    chk("nofwd_srv_data", Ld_RData, 32'h2);
    tick(); idle();
`endif
    chk("match_empty", Empty, 1);
    chk("match_mem", mem[8], 32'h2);

    // non-matching load with a pending entry
    store(32'h30, 32'h7, 32'h500);
    tick(); load(32'h40);
    @(negedge clk);
    chk("nm_addr", DM_Addr, 32'h40);
    chk("nm_wr", DM_MemWrite, 0);
    chk("nm_data", Ld_RData, 32'hDEADBEEF);
    chk("nm_stall", Stall, 0);
    chk("nm_nonempty", Empty, 0);
    tick(); idle();
    @(negedge clk);
    chk("nm_drain_wr", DM_MemWrite, 1);
    chk("nm_drain_addr", DM_Addr, 32'h30);
    chk("nm_drain_data", DM_WData, 32'h7);
    tick();
    chk("nm_empty", Empty, 1);

    // store and load together: load served, store refused
    store(32'h44, 32'h99, 32'h600);
    Ld_Valid = 1'b1; Ld_Addr = 32'h40;
    @(negedge clk);
    chk("both_stall", Stall, 1);
    chk("both_data", Ld_RData, 32'hDEADBEEF);
    chk("both_wr", DM_MemWrite, 0);
    tick(); idle();
    @(negedge clk);
    chk("both_not_acc", Empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-store write buffer between the MEM-stage access logic and the single-ported data memory. It queues MEM-stage stores and writes them into data memory only in cycles when no load or accepted store needs the port. Loads check the queue so they always return the newest stored value. Its outputs drive the data memory's address, write-data, write-enable and PC inputs directly; its load-data output feeds the MEM/WB register.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears the queue on the rising edge where it is high
- St_Valid  input  1  MEM stage issues a word store this cycle
- St_Addr  input  32  store byte address; bits [1:0] ignored
- St_WData  input  32  store data
- St_PC  input  32  PC of the store instruction, carried with the entry
- Ld_Valid  input  1  MEM stage issues a word load this cycle
- Ld_Addr  input  32  load byte address; bits [1:0] ignored
- Ld_RData  output  32  load result to MEM/WB
- Stall  output  1  MEM stage must hold its instruction this cycle
- DM_Addr  output  32  data-memory address
- DM_WData  output  32  data-memory write data
- DM_MemWrite  output  1  data-memory write enable
- DM_PC  output  32  PC passed to the data-memory write trace
- DM_RData  input  32  combinational data-memory read data at DM_Addr
- Empty  output  1  queue holds no entries

## Operation
- State: circular queue of DEPTH entries {word address [31:2], data, PC}, head pointer, tail pointer, count (0..DEPTH).
- St_Valid and Ld_Valid are mutually exclusive by contract. If both are high, the load is served, the store is not accepted, and Stall=1.
- Full = (count==DEPTH).
- Store accept: St_Valid && !Full && !Ld_Valid. Write the entry at the tail, increment the tail, and increment count.
- Store stall: St_Valid && Full. Stall=1. The port is free, so the queue drains one entry.
- Load match: Ld_Valid and some valid entry has a word address equal to Ld_Addr[31:2]. When several entries match, the youngest one wins.
- Load without match: DM_Addr=Ld_Addr, DM_MemWrite=0, Ld_RData=DM_RData, Stall=0, no drain.
- Drain condition: !Empty && !Ld_Valid && !(store accepted), or the load-stall case under Configuration. On drain:
  - DM_Addr = {head.addr, 2'b00}, DM_WData = head.data, DM_PC = head.PC, DM_MemWrite=1.
  - Head and count update at the edge.
- Idle (no drain, no load): DM_MemWrite=0, DM_Addr/DM_WData/DM_PC=0, Ld_RData=DM_RData.
- Drain order is strict FIFO. Drain and accept never happen in the same cycle, so count changes by at most 1 per cycle.
- Pointers wrap modulo DEPTH. Count distinguishes full from empty.

## Timing
- All outputs are combinational from the current state and inputs. State updates only on the rising edge.
- After reset: count=0, head=tail=0, Empty=1, Stall=0, DM_MemWrite=0. Entry contents are don't-care and never observable.
- reset takes precedence over every other event in the same cycle. Pending entries are discarded and not written to memory.
- A store accepted at edge N is visible to load matching from cycle N+1. It is drainable no earlier than cycle N+1.
- A stalled store is accepted no later than the next cycle, because the stall cycle always drains one entry.
- Load latency is 0 cycles, both for forwarded results and for DM_RData results.

## Configuration
- STORE_BUFFER_FORWARD_EN defined (forwarding on):
  - A load match returns Ld_RData = youngest matching entry data, with Stall=0.
  - DM_MemWrite=0 and no drain occur that cycle.
- STORE_BUFFER_FORWARD_EN undefined (forwarding off):
  - A load match asserts Stall=1, and the queue drains its head that cycle, with the drain driving the DM port.
  - The stall repeats until no entry matches; the load is then served from DM_RData.
- Both modes: non-matching loads behave identically.

## Test plan
- Reset mid-operation: 3 stores queued, then reset high for 1 cycle -> count=0, Empty=1, no DM_MemWrite with those addresses afterward.
- FIFO drain: stores 0x10<-0xA, 0x14<-0xB, then idle cycles -> DM_MemWrite writes 0x10=0xA, then 0x14=0xB on consecutive cycles, each with DM_PC equal to its store's PC; Empty=1 after.
- Full stall (DEPTH=4): 5 back-to-back stores -> Stall=1 only on the 5th cycle, with a drain of the oldest entry in that cycle; the 5th store is accepted in the next cycle; final memory holds all 5 values.
- Youngest match with forwarding on: stores 0x20<-1, 0x20<-2, then load 0x22 -> Ld_RData=2, Stall=0, DM_MemWrite=0.
- Youngest match with forwarding off: same sequence -> Stall=1 for 2 cycles while both entries drain, then Ld_RData=2 from DM_RData.
- Non-matching load with a pending entry: queue holds 0x30<-7, load 0x40 -> DM_Addr=0x40, DM_MemWrite=0, Ld_RData=DM_RData, count unchanged.
